// File: rtl/data_ram_bw.sv
// Simple-dual-port data RAM: per-byte write enables, valid/ready ports, 1- or 2-cycle
// read latency, and a clear engine that zeroes one word per cycle after reset or on request.
module data_ram_bw #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int RD_LAT     = 1,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DATA_W/8-1:0]   i_wbe,
   input  logic                  i_rvalid,
   output logic                  o_rready,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic                  o_rvalid,
   output logic [DATA_W-1:0]     o_rdata,
   output logic                  o_busy
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_RUN   = 1'b1;

   logic [0:0]         state;
   logic [ADDR_W-1:0]  cnt;
   logic [NB-1:0][7:0] mem [DEPTH];
   logic [NB-1:0][7:0] rd_word;
   logic               run, wr_acc, rd_acc;

   assign run      = (state == S_RUN);
   assign o_wready = run;
   assign o_rready = run;
   assign o_busy   = ~run;
   assign wr_acc   = i_wvalid & run;
   assign rd_acc   = i_rvalid & run;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT_CLEAR ? S_CLEAR : S_RUN;
         cnt   <= '0;
      end else if (!run) begin
         cnt <= cnt + ADDR_W'(1);
         if (cnt == ADDR_W'(DEPTH - 1))
            state <= S_RUN;
      end else if (i_clr) begin
         state <= S_CLEAR;
         cnt   <= '0;
      end
   end

   // Array has no reset; the clear engine owns the write port while not in RUN.
   always_ff @(posedge clk) begin
      if (!rst && !run)
         mem[cnt] <= '0;
      else if (!rst && wr_acc) begin
         for (int k = 0; k < NB; k++)
            if (i_wbe[k]) mem[i_waddr][k] <= i_wdata[8*k +: 8];
      end
   end

   // Write-first bypass for a same-cycle collision on the same word.
   always_comb begin
      rd_word = mem[i_raddr];
      if (wr_acc && (i_waddr == i_raddr)) begin
         for (int k = 0; k < NB; k++)
            if (i_wbe[k]) rd_word[k] = i_wdata[8*k +: 8];
      end
   end

   logic [RD_LAT:1]   vld_pipe;
   logic [DATA_W-1:0] rdata_q;

   if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_stage;
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_pipe <= '0;
            rdata_q  <= '0;
         end else begin
            vld_pipe <= {vld_pipe[1], rd_acc};
            if (rd_acc)      rd_stage <= rd_word;
            if (vld_pipe[1]) rdata_q  <= rd_stage;
         end
      end
   end else begin : g_lat1
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_pipe <= '0;
            rdata_q  <= '0;
         end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc) rdata_q <= rd_word;
         end
      end
   end

   assign o_rvalid = vld_pipe[RD_LAT];
   assign o_rdata  = rdata_q;
endmodule

// File: tb/tb_data_ram_bw.sv
// Randomized scoreboard bench: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// checked against an array-based reference model.
module tb_data_ram_bw;
   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_clr = 1'b0, i_wvalid = 1'b0, i_rvalid = 1'b0;
   logic [3:0]  i_waddr = '0, i_raddr = '0, i_wbe = '0;
   logic [31:0] i_wdata = '0;

   logic        wr [2], rr [2], rv [2], bz [2];
   logic [31:0] rd [2];

   exp_t        q [2][$];
   logic [31:0] hold [2];
   logic [31:0] ref_mem [DEPTH];
   int          busy_left = 0;
   int          cyc = 0;
   int          checks = 0, errors = 0;
   bit          mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_ram_bw #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .INIT_CLEAR(1'b1)) u_lat1 (
      .clk(clk), .rst(rst), .i_clr(i_clr),
      .i_wvalid(i_wvalid), .o_wready(wr[0]), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wbe(i_wbe),
      .i_rvalid(i_rvalid), .o_rready(rr[0]), .i_raddr(i_raddr),
      .o_rvalid(rv[0]), .o_rdata(rd[0]), .o_busy(bz[0]));

   data_ram_bw #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .INIT_CLEAR(1'b1)) u_lat2 (
      .clk(clk), .rst(rst), .i_clr(i_clr),
      .i_wvalid(i_wvalid), .o_wready(wr[1]), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wbe(i_wbe),
      .i_rvalid(i_rvalid), .o_rready(rr[1]), .i_raddr(i_raddr),
      .o_rvalid(rv[1]), .o_rdata(rd[1]), .o_busy(bz[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock of stimulus; the model decides acceptance from its own busy count.
   task automatic step(input logic r, input logic c, input logic wv, input logic [3:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic rvq, input logic [3:0] ra);
      bit          run, racc;
      logic [31:0] rexp;
      rst = r; i_clr = c; i_wvalid = wv; i_waddr = wa; i_wdata = wd; i_wbe = be;
      i_rvalid = rvq; i_raddr = ra;
      run  = (busy_left == 0);
      racc = 1'b0;
      rexp = '0;
      if (!r && run) begin
         if (wv)
            for (int k = 0; k < 4; k++)
               if (be[k]) ref_mem[wa][8*k +: 8] = wd[8*k +: 8];
         if (rvq) begin
            racc = 1'b1;
            rexp = ref_mem[ra];
         end
      end
      @(posedge clk); #1;
      if (r || (run && c)) begin
         busy_left = DEPTH;
         for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
      end else if (!run)
         busy_left--;
      if (r) begin
         for (int d = 0; d < 2; d++) begin
            q[d].delete();
            hold[d] = '0;
         end
      end
      if (racc) begin
         q[0].push_back('{rexp, cyc});
         q[1].push_back('{rexp, cyc + 1});
      end
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d),   32'(bz[d]), 32'(busy_left != 0));
            chk($sformatf("wready%0d", d), 32'(wr[d]), 32'(busy_left == 0));
            chk($sformatf("rready%0d", d), 32'(rr[d]), 32'(busy_left == 0));
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
   endtask
   task automatic wr_req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      step(1'b0, 1'b0, 1'b1, a, d, be, 1'b0, 4'd0);
   endtask
   task automatic rd_req(input logic [3:0] a);
      step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a);
   endtask
   // Random requests that must be ignored while clearing.
   task automatic noise();
      step(1'b0, 1'($urandom_range(1)), 1'b1, 4'($urandom), $urandom, 4'hF, 1'b1, 4'($urandom));
   endtask

   always @(negedge clk) begin
      exp_t it;
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            if (rv[d]) begin
               if (q[d].size() == 0)
                  chk($sformatf("stray_rvalid%0d", d), 32'd1, 32'd0);
               else begin
                  it = q[d].pop_front();
                  chk($sformatf("rdata%0d", d), rd[d], it.data);
                  chk($sformatf("rd_latency%0d", d), 32'(cyc), 32'(it.due));
                  hold[d] = it.data;
               end
            end else begin
               chk($sformatf("rdata_hold%0d", d), rd[d], hold[d]);
               if (q[d].size() != 0 && cyc >= q[d][0].due) begin
                  chk($sformatf("missing_rvalid%0d", d), 32'd0, 32'd1);
                  void'(q[d].pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Reset, then init clear: busy for exactly DEPTH cycles with requests ignored.
      repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
      mon_en = 1'b1;
      chk("reset_rvalid0", 32'(rv[0]), 32'd0);
      chk("reset_rdata1", rd[1], 32'd0);
      repeat (DEPTH) noise();
      for (int a = 0; a < DEPTH; a++) rd_req(4'(a));
      idle(); idle();

      // Byte-enable merge.
      wr_req(4'd3, 32'hAABBCCDD, 4'b1111);
      wr_req(4'd3, 32'h11223344, 4'b0101);
      rd_req(4'd3);
      idle(); idle();

      // Same-cycle collision, write-first.
      wr_req(4'd5, 32'h12345678, 4'b1111);
      step(1'b0, 1'b0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b0011, 1'b1, 4'd5);
      wr_req(4'd7, 32'h0, 4'b0000);
      rd_req(4'd7);

      // Back-to-back reads.
      for (int a = 0; a < 8; a++) wr_req(4'(a), $urandom, 4'hF);
      for (int a = 0; a < 8; a++) rd_req(4'(a));
      idle(); idle();

      // Read just before a clear still returns old data; afterwards zero.
      rd_req(4'd3);
      step(1'b0, 1'b1, 1'b1, 4'd9, 32'hDEADBEEF, 4'hF, 1'b1, 4'd3);
      repeat (DEPTH) noise();
      rd_req(4'd3);
      rd_req(4'd9);
      idle(); idle();

      // Reset at clear cycle 7 restarts the clear; a read in flight at reset is squashed.
      wr_req(4'd1, 32'hCAFEF00D, 4'hF);
      step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
      repeat (7) noise();
      step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
      repeat (DEPTH) noise();
      wr_req(4'd2, 32'h01020304, 4'hF);
      rd_req(4'd2);
      step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
      repeat (DEPTH) noise();
      rd_req(4'd1);

      // Random traffic with occasional clears and resets.
      for (int n = 0; n < 600; n++) begin
         logic [3:0] wa;
         wa = 4'($urandom);
         step(1'($urandom_range(249) == 0), 1'($urandom_range(79) == 0),
              1'($urandom_range(1)), wa, $urandom, 4'($urandom),
              1'($urandom_range(1)), ($urandom_range(3) == 0) ? wa : 4'($urandom));
      end
      repeat (DEPTH + 4) idle();
      chk("drain0", 32'(q[0].size()), 32'd0);
      chk("drain1", 32'(q[1].size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
